fir_mul_pipe: RTL and testbench

FIR_MUL_PIPE -- requirements
Module: fir_mul_pipe

---
 rtl/fir_mul_pipe_if.sv | 27 ++
 rtl/fir_mul_pipe.sv | 164 ++++++++++++++++
 tb/tb_fir_mul_pipe.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mul_pipe_if.sv
// Operand/result bundle for fir_mul_pipe; the master drives operands and
// control, the slave (the multiplier) returns the scaled result and flags.
interface fir_mul_pipe_if #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 12,
    parameter int DOUT_WIDTH = 16
);
    logic                  ce;
    logic                  din_vld;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  ovf_clr;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  dout_vld;
    logic                  dout_ovf;
    logic                  ovf_sticky;

    modport master (
        output ce, din_vld, din0, din1, ovf_clr,
        input  dout, dout_vld, dout_ovf, ovf_sticky
    );

    modport slave (
        input  ce, din_vld, din0, din1, ovf_clr,
        output dout, dout_vld, dout_ovf, ovf_sticky
    );
endinterface

// File: rtl/fir_mul_pipe.sv
// Pipelined fixed-point multiplier: exact product, optional round-half-up,
// arithmetic right shift, then saturate or wrap into DOUT_WIDTH bits.
module fir_mul_pipe #(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 2,
    parameter int DIN0_WIDTH  = 16,
    parameter int DIN1_WIDTH  = 12,
    parameter int DOUT_WIDTH  = 16,
    parameter int DIN0_SIGNED = 1,
    parameter int DIN1_SIGNED = 0,
    parameter int SHIFT       = 11,
    parameter int ROUND       = 1,
    parameter int SAT         = 1
) (
    input  logic          ap_clk,
    input  logic          ap_rst,
    fir_mul_pipe_if.slave bus
);
    // One bit wider than the exact product so the rounding add cannot overflow.
    localparam int PW         = DIN0_WIDTH + DIN1_WIDTH + 2;
    localparam int PRS        = (NUM_STAGE >= 3) ? NUM_STAGE - 2 : 0;
    localparam bit OUT_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
    localparam int RSH        = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [PW-1:0] RND_ADD =
        (ROUND != 0 && SHIFT > 0) ? (PW'(1) << RSH) : '0;
    localparam logic signed [PW-1:0] OMAX = OUT_SIGNED ?
        (PW'(1) << (DOUT_WIDTH - 1)) - PW'(1) : (PW'(1) << DOUT_WIDTH) - PW'(1);
    localparam logic signed [PW-1:0] OMIN = OUT_SIGNED ?
        -(PW'(1) << (DOUT_WIDTH - 1)) : '0;

    if (NUM_STAGE < 0 || NUM_STAGE > 4 || ID < 0 ||
        DOUT_WIDTH > DIN0_WIDTH + DIN1_WIDTH ||
        SHIFT < 0 || SHIFT > DIN0_WIDTH + DIN1_WIDTH - 1) begin : g_param_err
        $error("fir_mul_pipe: illegal parameter set");
    end

    logic [DIN0_WIDTH-1:0] w_a;
    logic [DIN1_WIDTH-1:0] w_b;
    logic                  w_ab_vld;

    if (NUM_STAGE >= 2) begin : g_op_reg
        logic [DIN0_WIDTH-1:0] r_a;
        logic [DIN1_WIDTH-1:0] r_b;
        logic                  r_vld;
        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                r_a   <= '0;
                r_b   <= '0;
                r_vld <= 1'b0;
            end else if (bus.ce) begin
                r_a   <= bus.din0;
                r_b   <= bus.din1;
                r_vld <= bus.din_vld;
            end
        end
        assign w_a      = r_a;
        assign w_b      = r_b;
        assign w_ab_vld = r_vld;
    end else begin : g_op_wire
        assign w_a      = bus.din0;
        assign w_b      = bus.din1;
        assign w_ab_vld = bus.din_vld;
    end

    logic signed [PW-1:0] w_x0;
    logic signed [PW-1:0] w_x1;
    logic signed [PW-1:0] w_prod;

    if (DIN0_SIGNED != 0) begin : g_x0s
        assign w_x0 = PW'(signed'(w_a));
    end else begin : g_x0u
        assign w_x0 = PW'(w_a);
    end
    if (DIN1_SIGNED != 0) begin : g_x1s
        assign w_x1 = PW'(signed'(w_b));
    end else begin : g_x1u
        assign w_x1 = PW'(w_b);
    end
    assign w_prod = w_x0 * w_x1;

    // Chain element 0 is the live product; element g+1 is the output of product stage g.
    logic signed [PW-1:0] w_pc [PRS+1];
    logic [PRS:0]         w_vc;
    assign w_pc[0] = w_prod;
    assign w_vc[0] = w_ab_vld;

    for (genvar g = 0; g < PRS; g++) begin : g_prod_reg
        logic signed [PW-1:0] r_prod;
        logic                 r_vld;
        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                r_prod <= '0;
                r_vld  <= 1'b0;
            end else if (bus.ce) begin
                r_prod <= w_pc[g];
                r_vld  <= w_vc[g];
            end
        end
        assign w_pc[g+1] = r_prod;
        assign w_vc[g+1] = r_vld;
    end

    logic signed [PW-1:0]  w_rnd;
    logic signed [PW-1:0]  w_s;
    logic                  w_ovf;
    logic [DOUT_WIDTH-1:0] w_y;

    assign w_rnd = w_pc[PRS] + RND_ADD;
    assign w_s   = w_rnd >>> SHIFT;
    assign w_ovf = (w_s > OMAX) || (w_s < OMIN);

    always_comb begin
        w_y = w_s[DOUT_WIDTH-1:0];
        if (SAT != 0 && w_s > OMAX)
            w_y = OMAX[DOUT_WIDTH-1:0];
        else if (SAT != 0 && w_s < OMIN)
            w_y = OMIN[DOUT_WIDTH-1:0];
    end

    logic [DOUT_WIDTH-1:0] w_out_dout;
    logic                  w_out_vld;
    logic                  w_out_ovf;

    if (NUM_STAGE >= 1) begin : g_out_reg
        logic [DOUT_WIDTH-1:0] r_dout;
        logic                  r_dvld;
        logic                  r_dovf;
        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                r_dout <= '0;
                r_dvld <= 1'b0;
                r_dovf <= 1'b0;
            end else if (bus.ce) begin
                r_dout <= w_y;
                r_dvld <= w_vc[PRS];
                r_dovf <= w_ovf;
            end
        end
        assign w_out_dout = r_dout;
        assign w_out_vld  = r_dvld;
        assign w_out_ovf  = r_dovf;
    end else begin : g_out_wire
        assign w_out_dout = w_y;
        assign w_out_vld  = w_vc[PRS];
        assign w_out_ovf  = w_ovf;
    end

    // Sticky flag ignores ce; a set on the same edge as a clear wins.
    logic r_sticky;
    always_ff @(posedge ap_clk) begin
        if (ap_rst)
            r_sticky <= 1'b0;
        else if (w_out_vld && w_out_ovf)
            r_sticky <= 1'b1;
        else if (bus.ovf_clr)
            r_sticky <= 1'b0;
    end

    assign bus.dout       = w_out_dout;
    assign bus.dout_vld   = w_out_vld;
    assign bus.dout_ovf   = w_out_ovf;
    assign bus.ovf_sticky = r_sticky;
endmodule

// File: tb/tb_fir_mul_pipe.sv
// Directed bench for fir_mul_pipe: streamed vector table over round/truncate,
// saturate/wrap and combinational variants, plus stall, sticky and reset sequences.
module tb_fir_mul_pipe;
    logic        clk;
    logic        rst;
    logic        ce;
    logic        vld;
    logic        clr;
    logic [15:0] d0;
    logic [11:0] d1;

    int total;
    int bad;

    fir_mul_pipe_if #(.DIN0_WIDTH(16), .DIN1_WIDTH(12), .DOUT_WIDTH(16)) if_m ();
    fir_mul_pipe_if #(.DIN0_WIDTH(16), .DIN1_WIDTH(12), .DOUT_WIDTH(16)) if_t ();
    fir_mul_pipe_if #(.DIN0_WIDTH(16), .DIN1_WIDTH(12), .DOUT_WIDTH(16)) if_w ();
    fir_mul_pipe_if #(.DIN0_WIDTH(16), .DIN1_WIDTH(12), .DOUT_WIDTH(16)) if_c ();

    assign if_m.ce = ce, if_m.din_vld = vld, if_m.din0 = d0, if_m.din1 = d1, if_m.ovf_clr = clr;
    assign if_t.ce = ce, if_t.din_vld = vld, if_t.din0 = d0, if_t.din1 = d1, if_t.ovf_clr = clr;
    assign if_w.ce = ce, if_w.din_vld = vld, if_w.din0 = d0, if_w.din1 = d1, if_w.ovf_clr = clr;
    assign if_c.ce = ce, if_c.din_vld = vld, if_c.din0 = d0, if_c.din1 = d1, if_c.ovf_clr = clr;

    fir_mul_pipe #(.NUM_STAGE(3)) u_main (.ap_clk(clk), .ap_rst(rst), .bus(if_m));
    fir_mul_pipe #(.NUM_STAGE(3), .ROUND(0)) u_trunc (.ap_clk(clk), .ap_rst(rst), .bus(if_t));
    fir_mul_pipe #(.NUM_STAGE(3), .SAT(0)) u_wrap (.ap_clk(clk), .ap_rst(rst), .bus(if_w));
    fir_mul_pipe #(.NUM_STAGE(0)) u_comb (.ap_clk(clk), .ap_rst(rst), .bus(if_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] d0;
        logic [11:0] d1;
        int          e_rnd;
        int          e_trn;
        int          e_wrap;
        bit          e_ovf;
    } vec_t;

    typedef struct {
        bit          ce;
        bit          vld;
        bit          rst;
        bit          clr;
        logic [15:0] d0;
        logic [11:0] d1;
        bit          chk;
        bit          ev;
        bit          cd;
        int          ed;
        bit          eo;
        bit          es;
    } step_t;

    vec_t  tv [13];
    step_t sq [$];

    function automatic vec_t mk(int a, int b, int er, int et, int ew, bit o);
        vec_t v;
        v.d0 = 16'(a);
        v.d1 = 12'(b);
        v.e_rnd = er;
        v.e_trn = et;
        v.e_wrap = ew;
        v.e_ovf = o;
        return v;
    endfunction

    function automatic step_t st(bit c, bit v, bit r, bit k, int a, int b,
                                 bit chk, bit ev, bit cd, int ed, bit eo, bit es);
        step_t s;
        s.ce = c; s.vld = v; s.rst = r; s.clr = k;
        s.d0 = 16'(a); s.d1 = 12'(b);
        s.chk = chk; s.ev = ev; s.cd = cd; s.ed = ed; s.eo = eo; s.es = es;
        return s;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_flush();
        for (int i = 0; i < 5; i++)
            sq.push_back(st(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        total = 0;
        bad   = 0;

        tv[0]  = mk(1000, 2048, 1000, 1000, 1000, 0);
        tv[1]  = mk(3, 1024, 2, 1, 2, 0);
        tv[2]  = mk(-3, 1024, -1, -2, -1, 0);
        tv[3]  = mk(-32768, 4095, -32768, -32768, 16, 1);
        tv[4]  = mk(32767, 4095, 32767, 32767, -18, 1);
        tv[5]  = mk(0, 4095, 0, 0, 0, 0);
        tv[6]  = mk(100, 100, 5, 4, 5, 0);
        tv[7]  = mk(-100, 100, -5, -5, -5, 0);
        tv[8]  = mk(32767, 2048, 32767, 32767, 32767, 0);
        tv[9]  = mk(-32768, 2048, -32768, -32768, -32768, 0);
        tv[10] = mk(32767, 2049, 32767, 32767, -32753, 1);
        tv[11] = mk(1, 1024, 1, 0, 1, 0);
        tv[12] = mk(-1, 1024, 0, -1, 0, 0);

        // Single sample, ce low for two cycles: result five cycles later; stalled input dropped.
        push_flush();
        sq.push_back(st(1, 1, 0, 0, 3, 1024, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(0, 1, 0, 0, 1000, 2048, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(0, 1, 0, 0, 1000, 2048, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 1, 1, 2, 0, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Outputs hold a valid result across a stall; overflowing stalled input is dropped.
        push_flush();
        sq.push_back(st(1, 1, 0, 0, 100, 100, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(1, 1, 0, 0, 3, 1024, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(1, 1, 0, 0, 1000, 2048, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(0, 1, 0, 0, -32768, 4095, 1, 1, 1, 5, 0, 0));
        sq.push_back(st(0, 1, 0, 0, -32768, 4095, 1, 1, 1, 5, 0, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 1, 1, 5, 0, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 1, 1, 2, 0, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 1, 1, 1000, 0, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Sticky: set beats a simultaneous clear; clear works with ce low.
        push_flush();
        sq.push_back(st(1, 1, 0, 0, -32768, 4095, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(1, 0, 0, 1, 0, 0, 1, 1, 1, -32768, 1, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        sq.push_back(st(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1));
        sq.push_back(st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Reset with ce low while the pipe is full: nothing from before survives.
        push_flush();
        sq.push_back(st(1, 1, 0, 0, 1000, 2048, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(1, 1, 0, 0, 32767, 4095, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(1, 1, 0, 0, 3, 1024, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(1, 1, 0, 0, 100, 100, 1, 1, 1, 1000, 0, 0));
        sq.push_back(st(0, 1, 1, 0, 100, 100, 1, 1, 1, 32767, 1, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        sq.push_back(st(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        rst = 1'b1; ce = 1'b1; vld = 1'b0; clr = 1'b0; d0 = '0; d1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst.dout", int'($signed(if_m.dout)), 0);
        check("rst.vld", int'(if_m.dout_vld), 0);
        check("rst.ovf", int'(if_m.dout_ovf), 0);
        check("rst.sticky", int'(if_m.ovf_sticky), 0);
        check("rst.trunc_vld", int'(if_t.dout_vld), 0);
        check("rst.wrap_vld", int'(if_w.dout_vld), 0);
        check("rst.comb_sticky", int'(if_c.ovf_sticky), 0);
        @(posedge clk);
        #1;

        // Back-to-back stream: vector c-3 is visible while vector c is presented.
        for (int c = 0; c < 16; c++) begin
            if (c < 13) begin
                vld = 1'b1; d0 = tv[c].d0; d1 = tv[c].d1;
            end else begin
                vld = 1'b0; d0 = '0; d1 = '0;
            end
            #1;
            if (c < 13) begin
                check($sformatf("tv%0d.comb_dout", c), int'($signed(if_c.dout)), tv[c].e_rnd);
                check($sformatf("tv%0d.comb_ovf", c), int'(if_c.dout_ovf), int'(tv[c].e_ovf));
                check($sformatf("tv%0d.comb_vld", c), int'(if_c.dout_vld), 1);
            end
            if (c >= 3) begin
                check($sformatf("tv%0d.vld", c - 3), int'(if_m.dout_vld), 1);
                check($sformatf("tv%0d.dout", c - 3), int'($signed(if_m.dout)), tv[c-3].e_rnd);
                check($sformatf("tv%0d.ovf", c - 3), int'(if_m.dout_ovf), int'(tv[c-3].e_ovf));
                check($sformatf("tv%0d.trunc_dout", c - 3), int'($signed(if_t.dout)), tv[c-3].e_trn);
                check($sformatf("tv%0d.trunc_ovf", c - 3), int'(if_t.dout_ovf), int'(tv[c-3].e_ovf));
                check($sformatf("tv%0d.wrap_dout", c - 3), int'($signed(if_w.dout)), tv[c-3].e_wrap);
                check($sformatf("tv%0d.wrap_ovf", c - 3), int'(if_w.dout_ovf), int'(tv[c-3].e_ovf));
            end else begin
                check($sformatf("fill%0d.vld", c), int'(if_m.dout_vld), 0);
            end
            @(posedge clk);
            #1;
        end

        foreach (sq[k]) begin
            ce = sq[k].ce; vld = sq[k].vld; rst = sq[k].rst; clr = sq[k].clr;
            d0 = sq[k].d0; d1 = sq[k].d1;
            #1;
            if (sq[k].chk) begin
                check($sformatf("seq%0d.vld", k), int'(if_m.dout_vld), int'(sq[k].ev));
                if (sq[k].cd) begin
                    check($sformatf("seq%0d.dout", k), int'($signed(if_m.dout)), sq[k].ed);
                    check($sformatf("seq%0d.ovf", k), int'(if_m.dout_ovf), int'(sq[k].eo));
                end
                check($sformatf("seq%0d.sticky", k), int'(if_m.ovf_sticky), int'(sq[k].es));
            end
            @(posedge clk);
            #1;
        end

        // Combinational variant ignores ce.
        ce = 1'b0; rst = 1'b0; clr = 1'b0; vld = 1'b1; d0 = 16'd1000; d1 = 12'd2048;
        #1;
        check("comb_ce0.dout", int'($signed(if_c.dout)), 1000);
        check("comb_ce0.vld", int'(if_c.dout_vld), 1);
        d0 = 16'h8000; d1 = 12'd4095;
        #1;
        check("comb_ce0.sat", int'($signed(if_c.dout)), -32768);
        check("comb_ce0.ovf", int'(if_c.dout_ovf), 1);
        vld = 1'b0;
        #1;
        check("comb_ce0.novld", int'(if_c.dout_vld), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
